// File: rtl/ahb_slave_mem_if.sv
// AHB-lite slave-side bus bundle: address/data phase signals from the
// master/decoder side and the slave's response signals.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-lite slave memory: word-organised RAM with byte/halfword/word writes,
// programmable wait states and a two-cycle ERROR response for illegal
// accesses. Address and data phases are pipelined, so a new transfer is
// taken on the same edge that completes the current data phase.
module ahb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            hresetn,
    ahb_slave_mem_if.slave  bus
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH * 4);
    // Counter preload so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [2:0]  WS_LOAD   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;
    logic [31:0]     hrdata_q, hrdata_d;

    logic [31:0]     mem_q [DEPTH];

    logic            ready_int;
    logic            accept;
    logic            illegal;
    logic            mem_we;
    logic [3:0]      be;
    logic [31:0]     rd_word;
    logic [31:0]     mem_wdata;
    logic            unused_htrans0;

    // Only htrans[1] distinguishes active from IDLE/BUSY transfers.
    assign unused_htrans0 = bus.htrans[0];

    // Address phase: acceptance and legality of the transfer on the bus.
    // The slave only takes a new address while its own data phase is
    // completing (or idle), so a stall elsewhere never double-captures.
    always_comb begin
        ready_int = (state_q != S_WAIT) && (state_q != S_ERR1);
        accept    = bus.hsel && bus.hready && bus.htrans[1] && ready_int;
        illegal   = ({1'b0, bus.haddr} >= MEM_BYTES)
                  || bus.hsize[2]
                  || (bus.hsize[1:0] == 2'b11)
                  || ((bus.hsize == 3'b001) && bus.haddr[0])
                  || ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00));
    end

    // Next state, wait counter and address-phase capture.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == 3'd0) state_d = S_DATA;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all end with hreadyout=1 and may
                // launch the next transfer on this edge.
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = bus.haddr[AW+1:2];
                    lane_d  = bus.haddr[1:0];
                    size_d  = bus.hsize[1:0];
                    write_d = bus.hwrite;
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WS_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    // Data phase: byte-lane enables, write merge and read-data hold.
    always_comb begin
        case (size_q)
            2'b00:   be = 4'b0001 << lane_q;
            2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        rd_word   = mem_q[idx_q];
        mem_we    = (state_q == S_DATA) && write_q;
        mem_wdata = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_wdata[8*b +: 8] = bus.hwdata[8*b +: 8];
        end
        // Read data is live during the read DATA cycle so a write committed
        // on the previous edge is already visible; otherwise hold.
        hrdata_d  = ((state_q == S_DATA) && !write_q) ? rd_word : hrdata_q;
    end

    assign bus.hreadyout = ready_int;
    assign bus.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.hrdata    = hrdata_d;

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 3'd0;
            idx_q    <= '0;
            lane_q   <= 2'd0;
            size_q   <= 2'd0;
            write_q  <= 1'b0;
            hrdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Memory array: contents survive reset; a reset edge suppresses the write.
    always_ff @(posedge clk) begin
        if (hresetn && mem_we) mem_q[idx_q] <= mem_wdata;
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (1 and 0 wait states) behind a
// small response mux, a pipelined master, a byte-level memory model and an
// expectation queue checked as each data phase completes.
module tb_ahb_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hresetn;
    logic        m_hsel, m_hwrite, m_hready_en, tgt;
    logic [31:0] m_haddr, m_hwdata;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize;

    ahb_slave_mem_if if_a ();
    ahb_slave_mem_if if_b ();

    ahb_slave_mem #(.DEPTH(64), .WAIT_STATES(1)) u_dut_ws1 (.clk(clk), .hresetn(hresetn), .bus(if_a));
    ahb_slave_mem #(.DEPTH(64), .WAIT_STATES(0)) u_dut_ws0 (.clk(clk), .hresetn(hresetn), .bus(if_b));

    assign if_a.hsel   = m_hsel & ~tgt;
    assign if_b.hsel   = m_hsel & tgt;
    assign if_a.haddr  = m_haddr;
    assign if_b.haddr  = m_haddr;
    assign if_a.htrans = m_htrans;
    assign if_b.htrans = m_htrans;
    assign if_a.hwrite = m_hwrite;
    assign if_b.hwrite = m_hwrite;
    assign if_a.hsize  = m_hsize;
    assign if_b.hsize  = m_hsize;
    assign if_a.hwdata = m_hwdata;
    assign if_b.hwdata = m_hwdata;
    assign if_a.hready = m_hready_en & if_a.hreadyout;
    assign if_b.hready = m_hready_en & if_b.hreadyout;

    logic        rdy, resp;
    logic [31:0] rdata;
    assign rdy   = tgt ? if_b.hreadyout : if_a.hreadyout;
    assign resp  = tgt ? if_b.hresp     : if_a.hresp;
    assign rdata = tgt ? if_b.hrdata    : if_a.hrdata;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } cmd_t;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    cmd_t        cmd_q [$];
    exp_t        exp_q [$];
    logic [7:0]  mem_m [2][256];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [1:0] trans);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.size = size; c.wdata = wdata; c.trans = trans;
        cmd_q.push_back(c);
    endtask

    // Build the expected response and update the model when a transfer is
    // committed to the bus on an edge that will accept it.
    task automatic expect_cmd(input cmd_t c);
        exp_t e;
        logic bad;
        logic [7:0] ba;
        bad = (c.addr >= 32'd256) || (c.size > 3'd2)
           || (c.size == 3'd1 && c.addr[0]) || (c.size == 3'd2 && c.addr[1:0] != 2'd0);
        e.err   = bad;
        e.rd    = !c.wr;
        e.waits = bad ? 1 : (tgt ? 0 : 1);
        e.data  = 32'd0;
        if (!bad) begin
            for (int b = 0; b < 4; b++) begin
                ba = {c.addr[7:2], 2'(b)};
                if (c.wr) begin
                    if ((c.size == 3'd0 && b == int'(c.addr[1:0])) ||
                        (c.size == 3'd1 && (b / 2) == int'(c.addr[1])) ||
                        (c.size == 3'd2))
                        mem_m[tgt][ba] = c.wdata[8*b +: 8];
                end else begin
                    e.data[8*b +: 8] = mem_m[tgt][ba];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Pipelined master: one transfer may be in its data phase while the
    // next address is put on the bus whenever the selected slave is ready.
    task automatic run(input int max_cyc);
        int   cyc = 0;
        int   dp_waits = 0;
        logic dp_v = 1'b0, pend_v = 1'b0;
        cmd_t pend, c;
        exp_t e;
        while ((cmd_q.size() != 0 || pend_v || dp_v) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (pend_v) begin
                dp_v = 1'b1; pend_v = 1'b0; dp_waits = 0;
                m_hwdata = pend.wdata;
            end
            if (dp_v) begin
                if (rdy) begin
                    e = exp_q.pop_front();
                    chk("resp", 32'(resp), 32'(e.err));
                    chk("waits", dp_waits, e.waits);
                    if (e.rd && !e.err) chk("rdata", rdata, e.data);
                    dp_v = 1'b0;
                end else begin
                    chk("stall_resp", 32'(resp), 32'(exp_q[0].err));
                    dp_waits++;
                end
            end
            if (rdy) begin
                if (cmd_q.size() != 0) begin
                    c = cmd_q.pop_front();
                    m_hsel = 1'b1; m_haddr = c.addr; m_htrans = c.trans;
                    m_hwrite = c.wr; m_hsize = c.size;
                    pend = c; pend_v = 1'b1;
                    expect_cmd(c);
                end else begin
                    m_hsel = 1'b0; m_htrans = 2'b00;
                end
            end
        end
        chk("drain", 32'(cmd_q.size() != 0 || pend_v || dp_v), 32'd0);
    endtask

    initial begin
        tgt = 1'b0; m_hready_en = 1'b1; hresetn = 1'b0;
        m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b1; m_haddr = 32'h0;
        m_hsize = 3'd2; m_hwdata = 32'hFFFF_FFFF;

        // Reset with an active NONSEQ on the bus.
        repeat (2) @(negedge clk);
        chk("rst_rdy_a", 32'(if_a.hreadyout), 32'd1);
        chk("rst_resp_a", 32'(if_a.hresp), 32'd0);
        chk("rst_rdata_a", if_a.hrdata, 32'd0);
        chk("rst_rdy_b", 32'(if_b.hreadyout), 32'd1);
        chk("rst_rdata_b", if_b.hrdata, 32'd0);
        m_hsel = 1'b0; m_htrans = 2'b00; hresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(if_a.hreadyout), 32'd1);
        chk("post_rst_resp", 32'(if_a.hresp), 32'd0);

        // Word write/read with one wait state.
        push(1'b1, 32'h00, 3'd2, 32'hCAFE_F00D, 2'b10);
        push(1'b1, 32'h08, 3'd2, 32'h1111_1111, 2'b10);
        push(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 2'b10);
        push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10);
        // Sub-word writes merge into one word.
        push(1'b1, 32'h20, 3'd2, 32'h0000_0000, 2'b10);
        push(1'b1, 32'h21, 3'd0, 32'h0000_AB00, 2'b10);
        push(1'b1, 32'h22, 3'd1, 32'h1234_0000, 2'b11);
        push(1'b0, 32'h20, 3'd2, 32'h0, 2'b10);
        // Illegal accesses, then confirm memory untouched.
        push(1'b0, 32'h13, 3'd2, 32'h0, 2'b10);
        push(1'b1, 32'h100, 3'd2, 32'h5A5A_5A5A, 2'b10);
        push(1'b1, 32'h21, 3'd1, 32'h7777_7777, 2'b10);
        push(1'b0, 32'h20, 3'd3, 32'h0, 2'b10);
        push(1'b0, 32'h00, 3'd2, 32'h0, 2'b10);
        push(1'b0, 32'h20, 3'd2, 32'h0, 2'b10);
        run(200);

        // Another slave stalling: hready=0 blocks acceptance.
        @(negedge clk);
        m_hready_en = 1'b0;
        m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b0; m_haddr = 32'h13; m_hsize = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy", 32'(if_a.hreadyout), 32'd1);
            chk("stall_noerr", 32'(if_a.hresp), 32'd0);
        end
        m_hsel = 1'b0; m_htrans = 2'b00; m_hready_en = 1'b1;
        @(negedge clk);
        chk("stall_after", 32'(if_a.hresp), 32'd0);

        // Reset during WAIT of a write aborts it.
        m_hsel = 1'b1; m_htrans = 2'b10; m_hwrite = 1'b1; m_haddr = 32'h08; m_hsize = 3'd2;
        m_hwdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("wait_seen", 32'(if_a.hreadyout), 32'd0);
        m_hsel = 1'b0; m_htrans = 2'b00; hresetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_rdy", 32'(if_a.hreadyout), 32'd1);
        hresetn = 1'b1;
        push(1'b0, 32'h08, 3'd2, 32'h0, 2'b10);
        run(50);

        // Zero wait states: back-to-back write then SEQ read.
        tgt = 1'b1;
        @(negedge clk);
        push(1'b1, 32'h04, 3'd2, 32'h0BAD_F00D, 2'b10);
        push(1'b0, 32'h04, 3'd2, 32'h0, 2'b11);
        push(1'b1, 32'h05, 3'd0, 32'h0000_3C00, 2'b10);
        push(1'b0, 32'h04, 3'd2, 32'h0, 2'b11);
        push(1'b0, 32'h101, 3'd0, 32'h0, 2'b10);
        push(1'b0, 32'h04, 3'd2, 32'h0, 2'b10);
        run(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
